// File: rtl/axi_r_framer_pkg.sv
// Shared types and constants for the AXI R-channel to AXI-Stream framer.
// Holds the FSM state encoding, header/trailer field positions and the beat counter width helper.
// Optional trailer beat is enabled by defining R_FRAMER_TRAILER_EN; TRAIL is always part of the enum.
package axi_r_framer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        TRAIL = 3'd4
    } state_t;

    // Header beat: rid sits at the bottom, ruser immediately above it, rest zero.
    localparam int HDR_RID_LSB  = 0;

    // Trailer beat field positions.
    localparam int TRL_CNT_LSB  = 0;
    localparam int TRL_CNT_W    = 16;
    localparam int TRL_RESP_BIT = 16;
    localparam int TRL_OVF_BIT  = 17;

    // Counter must represent 0..MAX_BEATS inclusive.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/axi_r_stream_framer_if.sv
// Bundle of the AXI4 R-channel input and AXI-Stream output of the framer.
// master: the surrounding system (drives R beats, drives tready, consumes the stream).
// slave : the framer (accepts R beats, drives the stream).
interface axi_r_stream_framer_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     s_rid;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rlast;
    logic [USER_WIDTH-1:0]   s_ruser;
    logic                    s_rvalid;
    logic                    s_rready;

    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                    m_axis_tuser;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;

    modport master (
        output s_rid, s_rdata, s_rresp, s_rlast, s_ruser, s_rvalid, m_axis_tready,
        input  s_rready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid
    );

    modport slave (
        input  s_rid, s_rdata, s_rresp, s_rlast, s_ruser, s_rvalid, m_axis_tready,
        output s_rready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid
    );
endinterface

// File: rtl/axis_skid_buf.sv
// 2-entry registered skid buffer: output register plus one overflow (skid) register.
// Latency 1 cycle input to output; full rate while i_out_rdy stays high.
// o_in_rdy is registered (low only while the skid entry is occupied); output payload holds while stalled.
// Ports: clk/reset; i_in_dat/i_in_vld/o_in_rdy upstream; o_out_dat/o_out_vld/i_out_rdy downstream.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_in_dat,
    input  logic         i_in_vld,
    output logic         o_in_rdy,
    output logic [W-1:0] o_out_dat,
    output logic         o_out_vld,
    input  logic         i_out_rdy
);
    logic [W-1:0] r_out_dat;
    logic [W-1:0] r_skid_dat;
    logic         r_out_vld;
    logic         r_skid_vld;

    assign o_in_rdy  = !r_skid_vld;
    assign o_out_dat = r_out_dat;
    assign o_out_vld = r_out_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_dat  <= '0;
            r_skid_dat <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_out_vld || i_out_rdy) begin
            // Output slot frees up: the skid entry (older) has priority.
            // Upstream cannot push in the same cycle because o_in_rdy is low then.
            if (r_skid_vld) begin
                r_out_dat  <= r_skid_dat;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= i_in_vld;
                if (i_in_vld) begin
                    r_out_dat <= i_in_dat;
                end
            end
        end else if (i_in_vld && !r_skid_vld) begin
            r_skid_dat <= i_in_dat;
            r_skid_vld <= 1'b1;
        end
    end
endmodule

// File: rtl/axi_r_stream_framer.sv
// Frames one AXI4 R burst as an AXI-Stream frame: header beat (rid, ruser) then data beats, tlast at end.
// Latency: header 1 cycle after s_rvalid seen in IDLE; data 1 cycle from acceptance; 1 beat/cycle sustained.
// Backpressure: s_rready drops when the skid buffer is full; output holds while tvalid && !tready.
// Ports: clk, reset (sync, active-high), bus (slave modport), frame_count, err_resp, err_overflow, err_id.
// Optional macro R_FRAMER_TRAILER_EN appends a trailer beat (count, resp error, overflow) to each frame.
module axi_r_stream_framer
    import axi_r_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64,
    parameter int MAX_BEATS  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_r_stream_framer_if.slave bus,
    output logic [31:0]          frame_count,
    output logic                 err_resp,
    output logic                 err_overflow,
    output logic                 err_id
);
    localparam int                CNT_W   = beat_cnt_width(MAX_BEATS);
    localparam int                PW      = DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BEATS);
    localparam int                HDR_USER_LSB = HDR_RID_LSB + ID_WIDTH;

    state_t            r_state, w_state_nxt;
    logic [ID_WIDTH-1:0] r_rid;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [31:0]       r_frame_count;
    logic              r_err_resp, r_err_overflow, r_err_id;

    logic              w_push, w_buf_rdy, w_rready, w_accept;
    logic              w_hdr_load, w_frame_inc, w_ovf_set, w_end;
    logic [PW-1:0]     w_push_dat;
    logic [PW-1:0]     w_out_dat;
    logic              w_out_vld;
    logic [DATA_WIDTH-1:0] w_hdr;

`ifdef R_FRAMER_TRAILER_EN
    logic              r_resp_or, r_frm_ovf;
    logic [DATA_WIDTH-1:0] w_trl;

    always_comb begin
        w_trl = '0;
        w_trl[TRL_CNT_LSB +: TRL_CNT_W] = TRL_CNT_W'(r_beat_cnt);
        w_trl[TRL_RESP_BIT] = r_resp_or;
        w_trl[TRL_OVF_BIT]  = r_frm_ovf;
    end
`endif

    assign w_cnt_nxt = r_beat_cnt + CNT_W'(1);
    assign w_accept  = bus.s_rvalid && w_rready;

    always_comb begin
        w_hdr = '0;
        w_hdr[HDR_RID_LSB +: ID_WIDTH]    = bus.s_rid;
        w_hdr[HDR_USER_LSB +: USER_WIDTH] = bus.s_ruser;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_dat  = '0;
        w_rready    = 1'b0;
        w_hdr_load  = 1'b0;
        w_frame_inc = 1'b0;
        w_ovf_set   = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            IDLE: begin
                // Peek at the first beat for rid/ruser without consuming it.
                if (bus.s_rvalid && w_buf_rdy) begin
                    w_push      = 1'b1;
                    w_push_dat  = {w_hdr, 1'b1, 1'b0};
                    w_hdr_load  = 1'b1;
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                // Only the header carries tuser=1, so this is its output handshake.
                if (w_out_vld && bus.m_axis_tready && w_out_dat[1]) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_rready = w_buf_rdy;
                if (w_accept) begin
                    w_push = 1'b1;
                    w_end  = bus.s_rlast || (w_cnt_nxt == MAX_CNT);
                    if (!bus.s_rlast && (w_cnt_nxt == MAX_CNT)) begin
                        w_ovf_set = 1'b1;
                    end
`ifdef R_FRAMER_TRAILER_EN
                    w_push_dat = {bus.s_rdata, 1'b0, 1'b0};
                    if (w_end) begin
                        w_state_nxt = TRAIL;
                    end
`else
                    w_push_dat = {bus.s_rdata, 1'b0, w_end};
                    if (w_end) begin
                        w_frame_inc = 1'b1;
                        w_state_nxt = bus.s_rlast ? IDLE : DRAIN;
                    end
`endif
                end
            end
            DRAIN: begin
                w_rready = 1'b1;
                if (w_accept && bus.s_rlast) begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef R_FRAMER_TRAILER_EN
            TRAIL: begin
                if (w_buf_rdy) begin
                    w_push      = 1'b1;
                    w_push_dat  = {w_trl, 1'b0, 1'b1};
                    w_frame_inc = 1'b1;
                    w_state_nxt = r_frm_ovf ? DRAIN : IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rid          <= '0;
            r_beat_cnt     <= '0;
            r_frame_count  <= '0;
            r_err_resp     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_id       <= 1'b0;
`ifdef R_FRAMER_TRAILER_EN
            r_resp_or      <= 1'b0;
            r_frm_ovf      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_err_resp <= w_accept && (bus.s_rresp != 2'b00);
            if (w_hdr_load) begin
                r_rid      <= bus.s_rid;
                r_beat_cnt <= '0;
`ifdef R_FRAMER_TRAILER_EN
                r_resp_or  <= 1'b0;
                r_frm_ovf  <= 1'b0;
`endif
            end
            if ((r_state == DATA) && w_accept) begin
                r_beat_cnt <= w_cnt_nxt;
                if (bus.s_rid != r_rid) begin
                    r_err_id <= 1'b1;
                end
`ifdef R_FRAMER_TRAILER_EN
                if (bus.s_rresp != 2'b00) begin
                    r_resp_or <= 1'b1;
                end
`endif
            end
            if (w_ovf_set) begin
                r_err_overflow <= 1'b1;
`ifdef R_FRAMER_TRAILER_EN
                r_frm_ovf      <= 1'b1;
`endif
            end
            if (w_frame_inc) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
        end
    end

    axis_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_in_dat  (w_push_dat),
        .i_in_vld  (w_push),
        .o_in_rdy  (w_buf_rdy),
        .o_out_dat (w_out_dat),
        .o_out_vld (w_out_vld),
        .i_out_rdy (bus.m_axis_tready)
    );

    assign bus.s_rready      = w_rready;
    assign bus.m_axis_tdata  = w_out_dat[PW-1:2];
    assign bus.m_axis_tuser  = w_out_dat[1];
    assign bus.m_axis_tlast  = w_out_dat[0];
    assign bus.m_axis_tvalid = w_out_vld;
    assign bus.m_axis_tkeep  = '1;

    assign frame_count  = r_frame_count;
    assign err_resp     = r_err_resp;
    assign err_overflow = r_err_overflow;
    assign err_id       = r_err_id;
endmodule

// File: tb/tb_axi_r_stream_framer.sv
// Self-checking bench for axi_r_stream_framer (default build, no trailer).
// Frame contents are predicted from burst descriptions and compared with captured output handshakes.
module tb_axi_r_stream_framer;
    localparam int DW   = 128;
    localparam int IW   = 32;
    localparam int UW   = 64;
    localparam int MAXB = 8;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          usr;
        logic          lst;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] frame_count;
    logic        err_resp, err_overflow, err_id;

    axi_r_stream_framer_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) bus ();

    axi_r_stream_framer #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MAX_BEATS(MAXB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .frame_count  (frame_count),
        .err_resp     (err_resp),
        .err_overflow (err_overflow),
        .err_id       (err_id)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    rdy_mode = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    exp_frames = 0;
    int    exp_resp = 0;
    bit    exp_ovf = 0;
    bit    exp_idchg = 0;
    int    resp_pulses = 0;
    bit    stall_prev = 0;
    beat_t stall_beat;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: captures handshakes, counts err_resp pulses, checks payload holds while stalled.
    always @(negedge clk) begin
        beat_t cur;
        cur = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
        if (!reset && stall_prev)
            check("stall_hold", 256'({bus.m_axis_tvalid, cur}), 256'({1'b1, stall_beat}));
        if (!reset && bus.m_axis_tvalid && bus.m_axis_tready) got_q.push_back(cur);
        if (err_resp) resp_pulses++;
        stall_prev = !reset && bus.m_axis_tvalid && !bus.m_axis_tready;
        stall_beat = cur;
    end

    initial begin
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = ~bus.m_axis_tready;
                default: bus.m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drive_beat(input logic [IW-1:0] rid, input logic [DW-1:0] dat,
                              input logic [1:0] resp, input logic last,
                              input logic [UW-1:0] user, output bit ok);
        int cyc;
        cyc = 0;
        ok = 0;
        bus.s_rvalid = 1'b1;
        bus.s_rid    = rid;
        bus.s_rdata  = dat;
        bus.s_rresp  = resp;
        bus.s_rlast  = last;
        bus.s_ruser  = user;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.s_rready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
    endtask

    // Reference model + driver for one burst. resp_at / id_at select a beat (0-based) with
    // rresp=2'b10 / a different rid; -1 means none.
    task automatic run_burst(input logic [IW-1:0] rid0, input logic [UW-1:0] user, input int n,
                             input bit seq, input int resp_at, input int id_at);
        beat_t         b;
        logic [DW-1:0] data_q[$];
        bit            ok, all_ok;
        for (int i = 0; i < n; i++)
            data_q.push_back(seq ? DW'(i + 1) : {$urandom, $urandom, $urandom, $urandom});
        b.dat = '0;
        b.dat[IW-1:0]  = rid0;
        b.dat[IW +: UW] = user;
        b.usr = 1'b1;
        b.lst = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < n && i < MAXB; i++) begin
            b.dat = data_q[i];
            b.usr = 1'b0;
            b.lst = (i == n - 1) || (i == MAXB - 1);
            exp_q.push_back(b);
        end
        exp_frames++;
        if (n > MAXB) exp_ovf = 1;
        if (resp_at >= 0 && resp_at < n) exp_resp++;
        if (id_at > 0 && id_at < n && id_at < MAXB) exp_idchg = 1;
        all_ok = 1;
        for (int i = 0; i < n; i++) begin
            drive_beat((i == id_at) ? rid0 + 1 : rid0, data_q[i],
                       (i == resp_at) ? 2'b10 : 2'b00, i == n - 1, user, ok);
            all_ok = all_ok && ok;
        end
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
        check("burst_accepted", 256'(all_ok), 256'(1'b1));
    endtask

    task automatic verify(input string tag);
        int cyc;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_beat_count"}, 256'(got_q.size()), 256'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_beat"}, 256'(got_q.pop_front()), 256'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
        check({tag, "_frame_count"}, 256'(frame_count), 256'(exp_frames));
        check({tag, "_err_overflow"}, 256'(err_overflow), 256'(exp_ovf));
        check({tag, "_err_id"}, 256'(err_id), 256'(exp_idchg));
        check({tag, "_err_resp_pulses"}, 256'(resp_pulses), 256'(exp_resp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.s_rvalid = 1'b0;
        bus.s_rid    = '0;
        bus.s_rdata  = '0;
        bus.s_rresp  = 2'b00;
        bus.s_rlast  = 1'b0;
        bus.s_ruser  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_rready", 256'(bus.s_rready), 256'(1'b0));
        check("rst_tvalid", 256'(bus.m_axis_tvalid), 256'(1'b0));
        check("rst_payload", 256'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}), 256'(0));
        check("rst_frame_count", 256'(frame_count), 256'(0));
        check("rst_errs", 256'({err_resp, err_overflow, err_id}), 256'(0));
        check("tkeep", 256'(bus.m_axis_tkeep), 256'({(DW/8){1'b1}}));

        // Single 4-beat burst, data 1..4, free-flowing output.
        rdy_mode = 0;
        run_burst(32'h5, 64'hAA, 4, 1, -1, -1);
        verify("single");

        // 8 beats (exactly MAX_BEATS with rlast: not an overflow) under alternating tready.
        rdy_mode = 1;
        run_burst(32'h1234_5678, 64'hDEAD_BEEF_0000_0001, 8, 0, -1, -1);
        verify("backpressure");

        // Error response on beat 2 of 3.
        rdy_mode = 0;
        run_burst(32'h42, 64'h7, 3, 0, 1, -1);
        verify("resp_err");

        // 10-beat burst overflows at 8; tail is drained; next burst frames normally.
        run_burst(32'h9, 64'h99, 10, 0, -1, -1);
        verify("overflow");
        run_burst(32'hA, 64'h1A, 3, 0, -1, -1);
        verify("after_overflow");

        // Back-to-back random bursts with random tready, including a single-beat frame.
        rdy_mode = 2;
        run_burst(32'hC0, 64'h0C, 1, 0, -1, -1);
        for (int k = 0; k < 6; k++)
            run_burst($urandom, {$urandom, $urandom}, $urandom_range(1, 6), 0, -1, -1);
        verify("random");

        // rid changes on beat 3: flagged, still forwarded.
        rdy_mode = 0;
        run_burst(32'h1, 64'h11, 4, 0, -1, 2);
        verify("id_change");

        // Reset after 2 of 4 beats.
        drive_beat(32'h3, 128'h1, 2'b00, 1'b0, 64'h3, ok);
        drive_beat(32'h3, 128'h2, 2'b00, 1'b0, 64'h3, ok);
        reset = 1'b1;
        bus.s_rvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", 256'(bus.m_axis_tvalid), 256'(1'b0));
        check("midrst_frame_count", 256'(frame_count), 256'(0));
        check("midrst_errs", 256'({err_overflow, err_id}), 256'(0));
        got_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_ovf    = 0;
        exp_idchg  = 0;
        run_burst(32'h77, 64'h5555, 3, 0, -1, -1);
        verify("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_r_stream_framer.md
Name: axi_r_stream_framer

Overview:
- Consumes an AXI4 read-data (R) channel burst and emits it as one AXI-Stream frame for the Ethernet egress path.
- Sits directly downstream of the R-channel pass-through stage.
- Each frame carries one header beat (rid, ruser), then the data beats. tlast marks the frame end.
- Fully registered outputs. Full-rate data transfer through a 2-entry skid buffer.

Parameters:
- DATA_WIDTH, 128, R data width and stream tdata width. Must be >= ID_WIDTH+USER_WIDTH.
- ID_WIDTH, 32, rid width.
- USER_WIDTH, 64, ruser width.
- MAX_BEATS, 256, maximum data beats per frame before forced termination.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- s_rid  in  ID_WIDTH  burst ID.
- s_rdata  in  DATA_WIDTH  read data.
- s_rresp  in  2  read response.
- s_rlast  in  1  last beat of burst.
- s_ruser  in  USER_WIDTH  user sideband.
- s_rvalid  in  1  beat valid.
- s_rready  out  1  beat accepted.
- m_axis_tdata  out  DATA_WIDTH  frame data.
- m_axis_tkeep  out  DATA_WIDTH/8  always all-ones.
- m_axis_tuser  out  1  1 = header beat.
- m_axis_tlast  out  1  frame end.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- frame_count  out  32  completed frames; wraps to 0 after 2^32-1.
- err_resp  out  1  one-cycle pulse when an accepted beat has s_rresp != 0.
- err_overflow  out  1  sticky; set when a burst exceeds MAX_BEATS.
- err_id  out  1  sticky; set when s_rid changes mid-burst.

Behaviour:
- Reset values: s_rready=0, m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, frame_count=0, all err_*=0, FSM=IDLE, skid buffer empty.
- Reset asserted mid-frame:
  - The partial frame is abandoned with no tlast.
  - m_axis_tvalid is 0 in the cycle after reset.
- FSM states: IDLE, HDR, DATA, DRAIN (plus TRAIL with the optional feature).
- IDLE:
  - s_rready=0.
  - On s_rvalid=1, latch s_rid and s_ruser and go to HDR. No beat is consumed.
  - The header is valid on the output 1 cycle later.
  - Header layout: tdata[ID_WIDTH-1:0]=rid; tdata[ID_WIDTH+USER_WIDTH-1:ID_WIDTH]=ruser; remaining bits 0; tuser=1; tlast=0.
- HDR: hold the header until tvalid&&tready, then go to DATA.
- DATA:
  - s_rready=1 while the skid buffer has a free entry.
  - Each accepted beat goes out with tuser=0 and tlast=s_rlast.
  - Latency is 1 cycle. Sustained throughput is 1 beat/cycle while tready=1.
  - A beat counter (width clog2(MAX_BEATS+1)) increments per accepted beat.
  - Accepted beat with rlast: frame_count++ and go to IDLE.
  - If s_rid differs from the latched rid: set err_id; the beat is still forwarded.
- Overflow: the beat that brings the counter to MAX_BEATS without rlast is emitted with tlast=1, sets err_overflow and counts as a frame. Then go to DRAIN.
- DRAIN: s_rready=1, outputs suppressed, remaining beats discarded. The beat with rlast returns the FSM to IDLE.
- Backpressure: the output holds tdata, tuser and tlast stable while tvalid&&!tready. No beat is lost or duplicated when tready toggles every cycle.
- Back-to-back bursts: the next header may be presented in the cycle after the previous tlast handshake.
- Zero-gap case: rvalid=1 with rlast on the first data beat gives a 2-beat frame (header + data, tlast on the data beat).

Optional Feature:
- Macro: R_FRAMER_TRAILER_EN.
- Defined:
  - After the rlast beat (or the overflow beat), the FSM enters TRAIL and emits one trailer beat with tuser=0 and tlast=1.
  - Trailer layout: tdata[15:0]=beat count; tdata[16]=OR of all (rresp!=0) in the frame; tdata[17]=overflow; other bits 0.
  - The preceding data beat then carries tlast=0.
  - frame_count increments on the trailer handshake.
- Undefined: no trailer; tlast is on the last data beat, as described above.

Decomposition:
- Package axi_r_framer_pkg holds:
  - the state enum (IDLE, HDR, DATA, DRAIN, TRAIL);
  - header field offset constants;
  - trailer bit positions;
  - the function computing the counter width.
- One sub-module: axis_skid_buf. It is a 2-entry registered skid buffer, parameterised on payload width, and carries {tdata, tuser, tlast}.

Test Plan:
- Single burst: rid=0x5, ruser=0xAA, 4 beats, data 1..4, tready=1 -> 5 output beats. Header tdata[31:0]=5, tdata[95:32]=0xAA, tuser=1. Data 1..4, tlast on data 4. frame_count=1.
- Backpressure: 8-beat burst with tready alternating 1/0 -> all 8 data beats in order, no duplicates; payload stable while stalled.
- Error: 3-beat burst with beat 2 rresp=2'b10 -> err_resp pulses exactly once. With R_FRAMER_TRAILER_EN, trailer tdata[16]=1 and tdata[15:0]=3.
- Overflow: MAX_BEATS=4, 6-beat burst -> 4 data beats out, tlast on the 4th. err_overflow=1. Beats 5–6 drained with s_rready=1. The next burst frames normally.
- Reset mid-frame: assert reset after 2 of 4 beats -> tvalid=0 and frame_count=0 next cycle. A fresh burst yields a correct header.
- ID change: burst rid=1 with beat 3 rid=2 -> err_id=1, all beats forwarded.
